// File: rtl/vector_register_file.sv
// rtl/vector_register_file.sv - 2-read/1-write vector register file with patterned async reset
module vector_register_file #(
   parameter int NUM_REGS  = 32,
   parameter int REG_WIDTH = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 WE3,
   input  logic [4:0]           A1,
   input  logic [4:0]           A2,
   input  logic [4:0]           A3,
   input  logic [REG_WIDTH-1:0] WD3,
   output logic [REG_WIDTH-1:0] RD1,
   output logic [REG_WIDTH-1:0] RD2
);

   localparam int LANES = REG_WIDTH / 32;

   logic [REG_WIDTH-1:0] regs [NUM_REGS];

   // Reset tags each lane with {register index, lane index} so every entry is distinguishable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            for (int j = 0; j < LANES; j++) begin
               regs[i][32*j +: 32] <= {i[15:0], j[15:0]};
            end
         end
      end else if (WE3) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (A3 == 5'(i)) begin
               regs[i] <= WD3;
            end
         end
      end
   end

   // Addresses with no matching entry fall through to the all-zero default.
   always_comb begin
      RD1 = '0;
      RD2 = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (A1 == 5'(i)) RD1 = regs[i];
         if (A2 == 5'(i)) RD2 = regs[i];
      end
   end

endmodule

// File: tb/tb_vector_register_file.sv
// tb/tb_vector_register_file.sv - randomized model-checked bench for vector_register_file
module tb_vector_register_file;

   localparam int NREGS = 24;
   localparam int W     = 256;

   logic         clk;
   logic         rst;
   logic         WE3;
   logic [4:0]   A1, A2, A3;
   logic [W-1:0] WD3;
   logic [W-1:0] RD1, RD2;

   int checks = 0;
   int errors = 0;
   bit seen_reset = 0;

   logic [W-1:0] model [NREGS];
   logic [W-1:0] rnd;
   logic [W-1:0] dead;

   vector_register_file #(.NUM_REGS(NREGS), .REG_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3),
      .WD3(WD3), .RD1(RD1), .RD2(RD2)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] pattern(input int r);
      logic [W-1:0] v;
      for (int j = 0; j < W/32; j++) v[32*j +: 32] = r * 65536 + j;
      return v;
   endfunction

   function automatic logic [W-1:0] expect_rd(input logic [4:0] a);
      if (int'(a) < NREGS) return model[a];
      return '0;
   endfunction

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] v;
      for (int j = 0; j < W/32; j++) v[32*j +: 32] = $urandom;
      return v;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) model[i] = pattern(i);
      end else if (WE3 && int'(A3) < NREGS) begin
         model[A3] = WD3;
      end
   end

   always @(negedge clk) begin
      if (seen_reset) begin
         check("rd1_model", RD1, expect_rd(A1));
         check("rd2_model", RD2, expect_rd(A2));
      end
   end

   initial begin
      rst = 1; WE3 = 0; A1 = 0; A2 = 0; A3 = 0; WD3 = '0;
      dead = {32'hDEADBEEF, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
      #1 rst = 0;
      seen_reset = 1;
      #11 rst = 1;
      A1 = 3; A2 = 5;
      #1;
      check("reset_reg3", RD1, {32'h00030007, 32'h00030006, 32'h00030005, 32'h00030004,
                                32'h00030003, 32'h00030002, 32'h00030001, 32'h00030000});
      check("reset_reg5_lane7", {224'd0, RD2[255:224]}, {224'd0, 32'h00050007});

      @(posedge clk) #2;
      WE3 = 1; A3 = 3; WD3 = dead;
      @(posedge clk) #2;
      WE3 = 0; A1 = 3; A2 = 0;
      #1;
      check("write_reg3", RD1, dead);
      check("reg0_reset", RD2, {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0});

      for (int r = 5; r <= 7; r++) begin
         A1 = 5'(r);
         #1 check("untouched", RD1, pattern(r));
      end

      A1 = 30; A2 = 5'(NREGS);
      #1;
      check("oob_rd1", RD1, '0);
      check("oob_rd2", RD2, '0);

      rst = 0;
      #12 rst = 1;
      A1 = 3;
      #1 check("reset_after_write", RD1, pattern(3));

      @(posedge clk) #2;
      WE3 = 0; A3 = 3;
      repeat (3) begin
         WD3 = rand_word();
         @(posedge clk) #2;
      end
      check("disabled_write", RD1, pattern(3));

      rnd = rand_word();
      A1 = 9; A3 = 9; WE3 = 1; WD3 = rnd;
      #6 check("rdw_before_edge", RD1, pattern(9));
      @(posedge clk) #1;
      check("rdw_after_edge", RD1, rnd);
      WE3 = 0;

      @(posedge clk) #2;
      rnd = rand_word();
      WE3 = 1; A3 = 4; A1 = 4; WD3 = rnd;
      #2 rst = 0;
      #1 check("async_reset_now", RD1, pattern(4));
      @(posedge clk) #1;
      check("reset_beats_write", RD1, pattern(4));
      #2 rst = 1;
      @(posedge clk) #1;
      check("write_resumes", RD1, rnd);
      WE3 = 0;

      for (int c = 0; c < 400; c++) begin
         @(posedge clk) #2;
         WE3 = $urandom_range(0, 1) == 1;
         A1  = 5'($urandom_range(0, 31));
         A2  = ($urandom_range(0, 3) == 0) ? A1 : 5'($urandom_range(0, 31));
         A3  = ($urandom_range(0, 1) == 1) ? A1 : 5'($urandom_range(0, 31));
         WD3 = rand_word();
         if ($urandom_range(0, 39) == 0) begin
            rst = 0;
            #1 check("rand_reset_rd1", RD1, expect_rd(A1));
            #1 rst = 1;
         end
      end

      @(posedge clk) #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
